xnor_conv_ctrl: RTL and testbench

XNOR_CONV_CTRL -- requirements
Module: xnor_conv_ctrl

---
 rtl/xnor_conv_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_xnor_conv_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/xnor_conv_ctrl.sv
// ----------------------------------------------------------------------------
// xnor_conv_ctrl
//
// Sequencer for a binary (XNOR/popcount) convolution PE array. A frame starts
// with a K*K weight-bit load, which can be skipped to reuse the weights already
// in the array. The image then streams in raster order, one pixel bit per
// accepted beat. The block produces the PE strobes and input-select controls,
// and marks each beat that completes a full K x K window.
//
// Handshake: a bit transfers on a rising edge where valid and ready are both
// high. Ready never depends on valid. While valid is low, nothing advances.
//
// Parameters:
//   K      kernel edge size (K x K window)
//   IMG_W  image width in pixels
//   IMG_H  image height in pixels
//
// Ports:
//   clk             sole clock, rising edge
//   rst             synchronous reset, active-high
//   cfg_start       start-frame pulse (honoured only in IDLE)
//   cfg_keep_w      sampled with cfg_start; 1 = reuse loaded weights
//   w_valid/w_ready weight-bit handshake (ready only while loading weights)
//   px_valid/px_ready pixel-bit handshake (ready only while running)
//   pe_en           PE array enable
//   weight_control  PE weight load strobe (one per accepted weight bit)
//   start           PE shift/accumulate strobe (one per accepted pixel)
//   top_start       PE top-register latch strobe (last column of a row)
//   side_control    PE input select: side neighbour
//   top_control     PE input select: top register
//   out_valid       one window result valid on the PE pcount outputs
//   busy            frame in progress
//   done            frame-complete pulse
// ----------------------------------------------------------------------------
module xnor_conv_ctrl #(
    parameter int K     = 3,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic cfg_start,
    input  logic cfg_keep_w,
    input  logic w_valid,
    output logic w_ready,
    input  logic px_valid,
    output logic px_ready,
    output logic pe_en,
    output logic weight_control,
    output logic start,
    output logic top_start,
    output logic side_control,
    output logic top_control,
    output logic out_valid,
    output logic busy,
    output logic done
);

    localparam int NW    = K * K;
    localparam int WC_W  = (NW    > 1) ? $clog2(NW)    : 1;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [WC_W-1:0]  W_LAST    = WC_W'(NW - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    // The first row/column at which a full K x K window is available.
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD_W = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [WC_W-1:0]  w_cnt, w_cnt_nxt;
    logic [COL_W-1:0] col, col_nxt;
    logic [ROW_W-1:0] row, row_nxt;

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            w_cnt     <= '0;
            col       <= '0;
            row       <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            w_cnt     <= w_cnt_nxt;
            col       <= col_nxt;
            row       <= row_nxt;
            // Flag the beat that completes a window. The PE pcount outputs
            // settle one cycle after that beat, which is why this is registered.
            out_valid <= start && (row >= ROW_FIRST) && (col >= COL_FIRST);
        end
    end

    // ------------------------------------------------------------------
    // Next-state, counter update and handshake readiness
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        w_cnt_nxt = w_cnt;
        col_nxt   = col;
        row_nxt   = row;
        w_ready   = 1'b0;
        px_ready  = 1'b0;

        case (state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                col_nxt   = '0;
                row_nxt   = '0;
                if (cfg_start) begin
                    state_nxt = cfg_keep_w ? S_RUN : S_LOAD_W;
                end
            end

            S_LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    if (w_cnt == W_LAST) begin
                        w_cnt_nxt = '0;
                        state_nxt = S_RUN;
                    end else begin
                        w_cnt_nxt = w_cnt + WC_W'(1);
                    end
                end
            end

            S_RUN: begin
                px_ready = 1'b1;
                if (px_valid) begin
                    if (col == COL_LAST) begin
                        col_nxt = '0;
                        if (row == ROW_LAST) begin
                            // Last pixel of the frame: counters return to 0
                            // instead of running past their terminal values.
                            row_nxt   = '0;
                            state_nxt = S_DONE;
                        end else begin
                            row_nxt = row + ROW_W'(1);
                        end
                    end else begin
                        col_nxt = col + COL_W'(1);
                    end
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PE strobes and input selects
    // ------------------------------------------------------------------
    assign weight_control = w_valid & w_ready;
    assign start          = px_valid & px_ready;
    assign top_start      = start && (col == COL_LAST);

    // Column 0 takes its operand from the top register, except in row 0.
    // Row 0, column 0 uses the bottom input, so both selects are low there.
    assign side_control   = (col != '0);
    assign top_control    = (col == '0) && (row != '0);

    assign busy           = (state != S_IDLE);
    assign pe_en          = busy;
    assign done           = (state == S_DONE);

endmodule

// File: tb/tb_xnor_conv_ctrl.sv
// ----------------------------------------------------------------------------
// tb_xnor_conv_ctrl
//
// Directed bench for xnor_conv_ctrl with K=3 and an 8x8 image. A reference
// model tracks the frame phase, the number of weights loaded and the linear
// pixel index. It derives row and column with division and modulo. Every
// output is compared against the model on each falling edge. Frame-level
// pulse totals and timings are then checked against hand-computed numbers.
// ----------------------------------------------------------------------------
module tb_xnor_conv_ctrl;

    localparam int K     = 3;
    localparam int IMG_W = 8;
    localparam int IMG_H = 8;

    // Model phases
    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_RUN  = 2;
    localparam int P_DONE = 3;

    logic clk = 1'b0;
    logic rst, cfg_start, cfg_keep_w, w_valid, px_valid;
    logic w_ready, px_ready, pe_en, weight_control, start, top_start;
    logic side_control, top_control, out_valid, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    // Clock / reset block
    always #5 clk = ~clk;

    xnor_conv_ctrl #(.K(K), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_start      (cfg_start),
        .cfg_keep_w     (cfg_keep_w),
        .w_valid        (w_valid),
        .w_ready        (w_ready),
        .px_valid       (px_valid),
        .px_ready       (px_ready),
        .pe_en          (pe_en),
        .weight_control (weight_control),
        .start          (start),
        .top_start      (top_start),
        .side_control   (side_control),
        .top_control    (top_control),
        .out_valid      (out_valid),
        .busy           (busy),
        .done           (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: updated on each rising edge from the applied inputs
    // ------------------------------------------------------------------
    int   m_phase = P_IDLE;
    int   m_wn    = 0;      // weights accepted so far
    int   m_pix   = 0;      // linear index of the next pixel
    logic m_ov    = 1'b0;   // expected out_valid for the coming cycle

    always @(posedge clk) begin
        if (rst) begin
            m_phase = P_IDLE;
            m_wn    = 0;
            m_pix   = 0;
            m_ov    = 1'b0;
        end else begin
            m_ov = 1'b0;
            case (m_phase)
                P_IDLE: if (cfg_start) m_phase = cfg_keep_w ? P_RUN : P_LOAD;
                P_LOAD: if (w_valid) begin
                    m_wn++;
                    if (m_wn == K * K) begin
                        m_wn    = 0;
                        m_phase = P_RUN;
                    end
                end
                P_RUN: if (px_valid) begin
                    m_ov = ((m_pix / IMG_W) >= K - 1) && ((m_pix % IMG_W) >= K - 1);
                    m_pix++;
                    if (m_pix == IMG_W * IMG_H) begin
                        m_pix   = 0;
                        m_phase = P_DONE;
                    end
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: per-cycle compare plus pulse accounting
    // ------------------------------------------------------------------
    int cyc = 0;
    int wc_n, st_n, ts_n, ov_n, dn_n;
    int first_ov_acc, last_st_cyc, done_cyc;

    logic [10:0] exp_v, act_v;
    logic        e_wr, e_pr, e_st;
    int          e_col, e_row;

    always @(negedge clk) begin
        cyc++;
        e_col = m_pix % IMG_W;
        e_row = m_pix / IMG_W;
        e_wr  = (m_phase == P_LOAD);
        e_pr  = (m_phase == P_RUN);
        e_st  = e_pr & px_valid;
        exp_v = {e_wr, e_wr & w_valid, e_pr, e_st,
                 e_st && (e_col == IMG_W - 1),
                 e_col != 0, (e_col == 0) && (e_row != 0),
                 m_ov, m_phase != P_IDLE, m_phase != P_IDLE, m_phase == P_DONE};
        act_v = {w_ready, weight_control, px_ready, start, top_start,
                 side_control, top_control, out_valid, busy, pe_en, done};
        chk("outputs", act_v, exp_v);

        if (weight_control) wc_n++;
        if (top_start) ts_n++;
        if (out_valid) begin
            if (first_ov_acc < 0) first_ov_acc = st_n;
            ov_n++;
        end
        if (done) begin
            dn_n++;
            done_cyc = cyc;
        end
        if (start) begin
            st_n++;
            last_st_cyc = cyc;
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic drive(input logic r, input logic cs, input logic kw,
                         input logic wv, input logic pv);
        rst        = r;
        cfg_start  = cs;
        cfg_keep_w = kw;
        w_valid    = wv;
        px_valid   = pv;
        @(posedge clk);
        #2;
    endtask

    task automatic clear_counts();
        wc_n = 0; st_n = 0; ts_n = 0; ov_n = 0; dn_n = 0;
        first_ov_acc = -1; last_st_cyc = 0; done_cyc = 0;
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        clear_counts();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_busy", busy, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_done", done, 0);

        // Frame A: load 9 weights, stream 64 pixels, stray cfg_start in RUN/DONE
        clear_counts();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("a_load_w_ready", w_ready, 1);
        repeat (9) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("a_run_px_ready", px_ready, 1);
        chk("a_run_w_ready", w_ready, 0);
        for (int i = 0; i < 64; i++)
            drive(1'b0, (i == 20 || i == 40), 1'b0, 1'b0, 1'b1);
        chk("a_done_now", done, 1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("a_idle_busy", busy, 0);
        chk("a_weight_pulses", wc_n, 9);
        chk("a_start_pulses", st_n, 64);
        chk("a_top_start_pulses", ts_n, 8);
        chk("a_out_valid_pulses", ov_n, 36);
        chk("a_done_pulses", dn_n, 1);
        chk("a_first_ov_after_accept", first_ov_acc, 19);
        chk("a_done_latency", done_cyc - last_st_cyc, 1);

        // Frame B: keep weights, px_valid toggles
        clear_counts();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("b_run_px_ready", px_ready, 1);
        chk("b_w_ready", w_ready, 0);
        for (int i = 0; i < 128; i++)
            drive(1'b0, 1'b0, 1'b0, 1'b0, (i % 2 == 0));
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("b_weight_pulses", wc_n, 0);
        chk("b_start_pulses", st_n, 64);
        chk("b_out_valid_pulses", ov_n, 36);
        chk("b_done_pulses", dn_n, 1);

        // Frame C: reset after 30 pixels, then a fresh frame
        clear_counts();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (30) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("c_ov_before_reset", out_valid, 1);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("c_reset_busy", busy, 0);
        chk("c_reset_out_valid", out_valid, 0);
        chk("c_reset_px_ready", px_ready, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        clear_counts();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (64) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("c_out_valid_pulses", ov_n, 36);
        chk("c_done_pulses", dn_n, 1);
        chk("c_idle_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
